// File: rtl/planning_move_arbiter.sv
// planning_move_arbiter: round-robin move arbiter for one robot (agent 0) and
// N_OBS obstacles (agents 1..N_OBS) on a GRID x GRID board, with a sticky
// collision flag.
// Optional build macro: PLANNING_COLLISION_BLOCK_EN. When it is defined, a move
// into a cell held by another agent is skipped during arbitration.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE_FIRST | first cycle after reset, no grants
//   RUN        | arbitrate one move per edge, watch for collisions
//   HALT       | collision seen; positions frozen, no grants until reset
module planning_move_arbiter #(
    parameter int N_OBS = 2,
    parameter int GRID  = 9,
    parameter int W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_OBS:0]         req,
    input  logic [2*(N_OBS+1)-1:0] dir,
    output logic [N_OBS:0]         grant,
    output logic [W*(N_OBS+1)-1:0] pos_x,
    output logic [W*(N_OBS+1)-1:0] pos_y,
    output logic                   error
);
    localparam int NA = N_OBS + 1;
    localparam int PW = $clog2(NA);
    localparam logic [W-1:0] MAXC = W'(GRID - 1);

    typedef enum logic [1:0] {IDLE_FIRST, RUN, HALT} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [W-1:0]  px [NA];
    logic [W-1:0]  py [NA];
    logic [W-1:0]  tx [NA];
    logic [W-1:0]  ty [NA];
    logic [NA-1:0] elig;
    logic          collide;
    logic          found;
    logic [PW-1:0] win;
    logic [PW-1:0] ptr_nxt;

    // Target cell per agent; a move off the board leaves the agent in place.
    always_comb begin
        for (int i = 0; i < NA; i++) begin
            tx[i] = px[i];
            ty[i] = py[i];
            case (dir[2*i +: 2])
                2'b00:   if (py[i] != MAXC) ty[i] = py[i] + 1'b1;
                2'b01:   if (py[i] != '0)   ty[i] = py[i] - 1'b1;
                2'b10:   if (px[i] != '0)   tx[i] = px[i] - 1'b1;
                default: if (px[i] != MAXC) tx[i] = px[i] + 1'b1;
            endcase
        end
    end

    // Requesters eligible for a grant this edge.
    always_comb begin
        for (int i = 0; i < NA; i++) begin
            elig[i] = req[i];
`ifdef PLANNING_COLLISION_BLOCK_EN
            for (int j = 0; j < NA; j++) begin
                if (j != i && tx[i] == px[j] && ty[i] == py[j]) elig[i] = 1'b0;
            end
`endif
        end
    end

    // Any two agents sharing a cell.
    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NA; i++) begin
            for (int j = i + 1; j < NA; j++) begin
                if (px[i] == px[j] && py[i] == py[j]) collide = 1'b1;
            end
        end
    end

    // Round-robin pick: first eligible at or above ptr, else first from 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NA; i++) begin
            if (!found && elig[i] && (i >= int'(ptr))) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
        for (int i = 0; i < NA; i++) begin
            if (!found && elig[i]) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
        ptr_nxt = (win == PW'(NA - 1)) ? '0 : win + 1'b1;
    end

    // Controller FSM, grant register, position registers and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE_FIRST;
            ptr   <= '0;
            grant <= '0;
            error <= 1'b0;
            for (int i = 0; i < NA; i++) begin
                px[i] <= (i == 0) ? '0 : W'(2);
                py[i] <= (i == 0) ? '0 : W'(i - 1);
            end
        end else begin
            case (state)
                IDLE_FIRST: begin
                    grant <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (collide) begin
                        error <= 1'b1;
                        grant <= '0;
                        state <= HALT;
                    end else if (found) begin
                        grant   <= {{(NA-1){1'b0}}, 1'b1} << win;
                        px[win] <= tx[win];
                        py[win] <= ty[win];
                        ptr     <= ptr_nxt;
                    end else begin
                        grant <= '0;
                    end
                end
                default: grant <= '0;
            endcase
        end
    end

    // Flatten the position arrays onto the output buses.
    always_comb begin
        pos_x = '0;
        pos_y = '0;
        for (int i = 0; i < NA; i++) begin
            pos_x[W*i +: W] = px[i];
            pos_y[W*i +: W] = py[i];
        end
    end

endmodule
